// File: rtl/move_entry_fsm.sv
// move_entry_fsm: maps the mouse cursor to a board square and sequences a local move
// (pick, hold, destination, place) with legality gating and cancellation, one decision per frame_tick.
// Optional: define MOVE_ENTRY_TIMEOUT_EN to auto-cancel a pick after TIMEOUT_FRAMES ticks.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   frame_tick                      per-frame sampling strobe
//   mouse_xpos/ypos/left/right      cursor position and buttons (right = cancel)
//   my_color, turn_start            local colour, turn grant pulse
//   possible_moves, sq_piece        legal-destination mask, piece under sq_addr
//   sq_addr                         combinational cursor square
//   cursor_sq, cursor_valid         registered cursor square / on-board flag
//   pick_valid, pick_sq             current pick
//   move_valid, move_from, move_to  commit pulse and squares
//   move_cancel                     cancel pulse
//   led                             one-hot {HOLD_PLACE, WAIT_DEST, HOLD_PICK, SELECT}
module move_entry_fsm #(
    parameter int BOARD_N = 8,
    parameter int SQ_SHIFT = 6,
    parameter int X0 = 256,
    parameter int Y0 = 128,
    parameter int PIECE_W = 4,
    parameter int HALF = 6,
    parameter int TIMEOUT_FRAMES = 600,
    localparam int RW = $clog2(BOARD_N),
    localparam int IDX_W = 2 * RW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_tick,
    input  logic [11:0]                mouse_xpos,
    input  logic [11:0]                mouse_ypos,
    input  logic                       mouse_left,
    input  logic                       mouse_right,
    input  logic                       my_color,
    input  logic                       turn_start,
    input  logic [BOARD_N*BOARD_N-1:0] possible_moves,
    input  logic [PIECE_W-1:0]         sq_piece,
    output logic [IDX_W-1:0]           sq_addr,
    output logic [IDX_W-1:0]           cursor_sq,
    output logic                       cursor_valid,
    output logic                       pick_valid,
    output logic [IDX_W-1:0]           pick_sq,
    output logic                       move_valid,
    output logic [IDX_W-1:0]           move_from,
    output logic [IDX_W-1:0]           move_to,
    output logic                       move_cancel,
    output logic [3:0]                 led
);
    typedef enum logic [2:0] {IDLE, SELECT, HOLD_PICK, WAIT_DEST, HOLD_PLACE} state_t;
    localparam logic [12:0] EXT = 13'(BOARD_N << SQ_SHIFT);
    state_t state, nstate;
    logic [12:0] dx, dy;
    logic on_board, own, tmo, turn_pend, cflag, dest_self;
    logic do_pick, do_dest, do_commit, do_cancel;
    logic [IDX_W-1:0] dest;
    // Bit 12 of the 13-bit difference is the sign: negative means left of / above the board.
    assign dx = {1'b0, mouse_xpos} - 13'(X0);
    assign dy = {1'b0, mouse_ypos} - 13'(Y0);
    assign on_board = !dx[12] && !dy[12] && dx < EXT && dy < EXT;
    assign sq_addr = {dy[SQ_SHIFT +: RW], dx[SQ_SHIFT +: RW]};
    assign own = sq_piece != '0 && (my_color ? sq_piece > PIECE_W'(HALF) : sq_piece <= PIECE_W'(HALF));
    assign led = {state == HOLD_PLACE, state == WAIT_DEST, state == HOLD_PICK, state == SELECT};
    always_comb begin
        nstate = state;
        do_pick = 1'b0;
        do_dest = 1'b0;
        do_commit = 1'b0;
        do_cancel = 1'b0;
        dest_self = 1'b0;
        if (frame_tick) begin
            case (state)
                IDLE:       nstate = (turn_pend || turn_start) ? SELECT : IDLE;
                SELECT:     do_pick = mouse_left && on_board && own;
                HOLD_PICK:  begin
                    do_cancel = mouse_right || tmo;
                    nstate = (!do_cancel && !mouse_left) ? WAIT_DEST : state;
                end
                WAIT_DEST:  begin
                    do_cancel = mouse_right || tmo;
                    dest_self = sq_addr == pick_sq;
                    do_dest = !do_cancel && mouse_left && on_board && (dest_self || possible_moves[sq_addr]);
                end
                HOLD_PLACE: begin
                    do_cancel = !mouse_left && cflag;
                    do_commit = !mouse_left && !cflag;
                end
                default:    nstate = IDLE;
            endcase
            nstate = do_pick ? HOLD_PICK : do_dest ? HOLD_PLACE : do_cancel ? SELECT : do_commit ? IDLE : nstate;
        end
    end
`ifdef MOVE_ENTRY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_FRAMES + 1);
    logic [TW-1:0] tmo_cnt;
    // The tick that would bring the count to TIMEOUT_FRAMES is the one that cancels.
    assign tmo = tmo_cnt == TW'(TIMEOUT_FRAMES - 1);
    always_ff @(posedge clk) begin
        if (rst)
            tmo_cnt <= '0;
        else if (frame_tick)
            tmo_cnt <= (nstate != state || !(state inside {HOLD_PICK, WAIT_DEST})) ? '0 : tmo_cnt + 1'b1;
    end
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_FRAMES;
    assign tmo = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            turn_pend <= 1'b0;
            cursor_sq <= '0;
            cursor_valid <= 1'b0;
            pick_valid <= 1'b0;
            pick_sq <= '0;
            dest <= '0;
            cflag <= 1'b0;
            move_valid <= 1'b0;
            move_from <= '0;
            move_to <= '0;
            move_cancel <= 1'b0;
        end else begin
            state <= nstate;
            // A turn grant between ticks is held so the next tick can act on it.
            turn_pend <= frame_tick ? 1'b0 : (turn_pend || (turn_start && state == IDLE));
            move_valid <= do_commit;
            move_cancel <= do_cancel;
            if (frame_tick) begin
                cursor_sq <= sq_addr;
                cursor_valid <= on_board;
            end
            if (do_pick) begin
                pick_sq <= sq_addr;
                pick_valid <= 1'b1;
            end
            if (do_commit || do_cancel)
                pick_valid <= 1'b0;
            if (do_dest) begin
                dest <= sq_addr;
                cflag <= dest_self;
            end
            if (do_commit) begin
                move_from <= pick_sq;
                move_to <= dest;
            end
        end
    end
endmodule
